tis_link: RTL and testbench
===========================

// Module: tis_link
// PURPOSE
//  Bidirectional blocking port between two adjacent TIS nodes (node A = left/up, node B = right/down).
//  Sits directly downstream of each core's MOV/ADD/SUB operand path: a core writing to a port
//  stalls until the neighbour reads, matching TIS-100 rendezvous semantics. Each direction is one
//  single-word mailbox. Value width is the 11-bit signed ACC format (-999..999).
// PARAMETERS
//  DW      11  data width, two's complement
//  BYPASS  1   1: same-cycle write+read on empty slot completes in one cycle; 0: always >=2 cycles
//  VMAX    999 saturation limit applied to written values (+/-VMAX)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  a_wr_valid in   1   node A presents a word for B; held high until a_wr_done
//  a_wr_data  in   DW  word from A; stable while a_wr_valid
//  a_wr_done  out  1   1-cycle pulse: B consumed A's word, A may retire its instruction
//  a_rd_req   in   1   node A blocked reading from B; held high until a_rd_ack
//  a_rd_data  out  DW  word from B, valid in a_rd_ack cycle
//  a_rd_ack   out  1   1-cycle pulse: a_rd_data valid, A retires the read
//  b_wr_valid/b_wr_data/b_wr_done/b_rd_req/b_rd_data/b_rd_ack: mirror of A ports, direction B->A
//  a2b_full   out  1   status: A->B slot occupied (debug / deadlock monitor)
//  b2a_full   out  1   status: B->A slot occupied
// BEHAVIOUR
//  Reset (rst=0, async): both slots EMPTY; all *_done, *_ack, *_full = 0; *_rd_data = 0.
//  Per-direction FSM (writer W, reader R), states EMPTY, FULL, DRAIN:
//   EMPTY: W valid & !(BYPASS & R req) -> latch sat(data), FULL. W valid & R req & BYPASS ->
//          rd_data = sat(wr_data) comb, rd_ack=1 and wr_done=1 same cycle, stay EMPTY.
//   FULL : R req -> rd_ack=1, rd_data=slot, go DRAIN. Else hold. New W data ignored (W stalled).
//   DRAIN: wr_done=1 for exactly one cycle -> EMPTY. W must drop wr_valid in this cycle's
//          following edge or present next word; next word accepted no earlier than EMPTY.
//  Latency: non-bypass write-then-read = rd_ack 1 cycle after both asserted, wr_done 1 after ack.
//  Saturation: sat(x) = x>VMAX ? VMAX : x<-VMAX ? -VMAX : x, on DW-bit signed compare.
//  Reader asserts rd_req with slot EMPTY and no writer: no ack; reader stalls indefinitely.
//  Both nodes writing to each other simultaneously: both slots fill, both wait; deadlock is legal
//  TIS behaviour, not resolved here; a2b_full & b2a_full & no rd_req flags it externally.
//  Both nodes reading simultaneously with empty slots: both stall, no acks.
//  Both directions fully independent; A->B and B->A transfers may complete in the same cycle.
//  rd_req dropped before ack (illegal): FSM holds state, no ack; word stays in slot.
//  wr_valid dropped while FULL (illegal): word remains, still deliverable; wr_done still pulses.
//  Reset mid-transfer: word discarded, no done/ack pulses emitted after rst rises.
//  *_rd_data outside ack cycle: holds last delivered value (no X).
// STRUCTURE
//  tis_pkg: typedef logic signed [10:0] tis_word_t; localparam TIS_VMAX = 999;
//           typedef enum logic [1:0] {CH_EMPTY, CH_FULL, CH_DRAIN} ch_state_t; function tis_sat().
//  Sub-module tis_channel: one unidirectional mailbox + FSM; tis_link instantiates two
//  (a2b, b2a) and wires status outputs. No other hierarchy.
// TESTING
//  1 Reset: rst=0 with a_wr_valid=1 -> all done/ack/full 0; release -> a2b_full=1 next edge.
//  2 A writes 5, B reads 3 cycles later (BYPASS=0) -> b_rd_ack with b_rd_data=5, a_wr_done next cycle.
//  3 BYPASS=1, A writes -7 and B reads same cycle -> b_rd_ack & a_wr_done same cycle, data -7.
//  4 A writes 1500 / -1200 -> B reads 999 / -999.
//  5 A and B write each other (3, 4) simultaneously, then both read -> both deliver, no cross-talk.
//  6 Slot FULL with 42, assert rst=0 mid-wait -> slot EMPTY, later B read stalls (no ack).

Source files
------------

// File: rtl/tis_pkg.sv
// rtl/tis_pkg.sv - shared types, limits and saturation helper for TIS port links
package tis_pkg;

  localparam int TIS_VMAX = 999;

  typedef logic signed [10:0] tis_word_t;

  typedef enum logic [1:0] {
    CH_EMPTY = 2'd0,
    CH_FULL  = 2'd1,
    CH_DRAIN = 2'd2
  } ch_state_t;

  // Clamp an ACC-format word into +/-vmax
  function automatic tis_word_t tis_sat(input tis_word_t x, input tis_word_t vmax);
    tis_word_t r;
    if (x > vmax) begin
      r = vmax;
    end else if (x < -vmax) begin
      r = -vmax;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/tis_channel.sv
// rtl/tis_channel.sv - one-direction single-word rendezvous mailbox with handshake FSM
module tis_channel
  import tis_pkg::*;
#(
  parameter int DW     = 11,
  parameter int BYPASS = 1,
  parameter int VMAX   = TIS_VMAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_done_o,
  input  logic          rd_req_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_ack_o,
  output logic          full_o
);

  localparam logic signed [DW-1:0] VMAX_P = DW'(VMAX);
  localparam logic signed [DW-1:0] VMIN_P = -VMAX_P;

  ch_state_t     state_q, state_d;
  logic [DW-1:0] slot_q, slot_d;
  logic [DW-1:0] last_q, last_d;
  logic [DW-1:0] sat_data;
  logic [DW-1:0] deliver;
  logic          ack;
  logic          done;

  // Saturate the incoming word to the legal ACC range on a signed compare
  always_comb begin
    sat_data = wr_data_i;
    if ($signed(wr_data_i) > VMAX_P) begin
      sat_data = VMAX_P;
    end else if ($signed(wr_data_i) < VMIN_P) begin
      sat_data = VMIN_P;
    end
  end

  // Next-state, slot capture and handshake pulses
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ack     = 1'b0;
    done    = 1'b0;
    deliver = slot_q;
    unique case (state_q)
      CH_EMPTY: begin
        if (wr_valid_i) begin
          if ((BYPASS != 0) && rd_req_i) begin
            // Writer and reader meet on an empty slot: hand the word straight across
            ack     = 1'b1;
            done    = 1'b1;
            deliver = sat_data;
          end else begin
            slot_d  = sat_data;
            state_d = CH_FULL;
          end
        end
      end
      CH_FULL: begin
        // Writer stays stalled here; its bus is ignored until the slot drains
        if (rd_req_i) begin
          ack     = 1'b1;
          state_d = CH_DRAIN;
        end
      end
      CH_DRAIN: begin
        done    = 1'b1;
        state_d = CH_EMPTY;
      end
      default: begin
        state_d = CH_EMPTY;
      end
    endcase
  end

  // Remember the last delivered word so rd_data never floats between acks
  always_comb begin
    last_d = last_q;
    if (ack) begin
      last_d = deliver;
    end
  end

  // State, slot and last-delivered registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CH_EMPTY;
      slot_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      last_q  <= last_d;
    end
  end

  // Pulses are masked while reset is held so a bypass cannot fire during reset
  assign rd_ack_o  = ack & rst;
  assign wr_done_o = done & rst;
  assign rd_data_o = rd_ack_o ? deliver : last_q;
  assign full_o    = (state_q == CH_FULL);

endmodule

// File: rtl/tis_link.sv
// rtl/tis_link.sv - bidirectional blocking port between two adjacent TIS nodes
module tis_link
  import tis_pkg::*;
#(
  parameter int DW     = 11,
  parameter int BYPASS = 1,
  parameter int VMAX   = TIS_VMAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_wr_valid,
  input  logic [DW-1:0] a_wr_data,
  output logic          a_wr_done,
  input  logic          a_rd_req,
  output logic [DW-1:0] a_rd_data,
  output logic          a_rd_ack,
  input  logic          b_wr_valid,
  input  logic [DW-1:0] b_wr_data,
  output logic          b_wr_done,
  input  logic          b_rd_req,
  output logic [DW-1:0] b_rd_data,
  output logic          b_rd_ack,
  output logic          a2b_full,
  output logic          b2a_full
);

  // A writes, B reads
  tis_channel #(.DW(DW), .BYPASS(BYPASS), .VMAX(VMAX)) u_a2b (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (a_wr_valid),
    .wr_data_i  (a_wr_data),
    .wr_done_o  (a_wr_done),
    .rd_req_i   (b_rd_req),
    .rd_data_o  (b_rd_data),
    .rd_ack_o   (b_rd_ack),
    .full_o     (a2b_full)
  );

  // B writes, A reads
  tis_channel #(.DW(DW), .BYPASS(BYPASS), .VMAX(VMAX)) u_b2a (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (b_wr_valid),
    .wr_data_i  (b_wr_data),
    .wr_done_o  (b_wr_done),
    .rd_req_i   (a_rd_req),
    .rd_data_o  (a_rd_data),
    .rd_ack_o   (a_rd_ack),
    .full_o     (b2a_full)
  );

endmodule

// File: tb/tb_tis_link.sv
// tb/tb_tis_link.sv - self-checking bench for tis_link with a timing/saturation reference model
module tb_tis_link;

  logic        clk;
  logic        rst;
  logic        a_wr_valid, a_rd_req, b_wr_valid, b_rd_req;
  logic [10:0] a_wr_data, b_wr_data;
  logic        a_wr_done, a_rd_ack, b_wr_done, b_rd_ack;
  logic [10:0] a_rd_data, b_rd_data;
  logic        a2b_full, b2a_full;

  logic        n_a_wr_valid, n_a_rd_req, n_b_wr_valid, n_b_rd_req;
  logic [10:0] n_a_wr_data, n_b_wr_data;
  logic        n_a_wr_done, n_a_rd_ack, n_b_wr_done, n_b_rd_ack;
  logic [10:0] n_a_rd_data, n_b_rd_data;
  logic        n_a2b_full, n_b2a_full;

  int total = 0;
  int bad   = 0;

  tis_link #(.DW(11), .BYPASS(1), .VMAX(999)) dut (
    .clk(clk), .rst(rst),
    .a_wr_valid(a_wr_valid), .a_wr_data(a_wr_data), .a_wr_done(a_wr_done),
    .a_rd_req(a_rd_req), .a_rd_data(a_rd_data), .a_rd_ack(a_rd_ack),
    .b_wr_valid(b_wr_valid), .b_wr_data(b_wr_data), .b_wr_done(b_wr_done),
    .b_rd_req(b_rd_req), .b_rd_data(b_rd_data), .b_rd_ack(b_rd_ack),
    .a2b_full(a2b_full), .b2a_full(b2a_full)
  );

  tis_link #(.DW(11), .BYPASS(0), .VMAX(999)) dut_nb (
    .clk(clk), .rst(rst),
    .a_wr_valid(n_a_wr_valid), .a_wr_data(n_a_wr_data), .a_wr_done(n_a_wr_done),
    .a_rd_req(n_a_rd_req), .a_rd_data(n_a_rd_data), .a_rd_ack(n_a_rd_ack),
    .b_wr_valid(n_b_wr_valid), .b_wr_data(n_b_wr_data), .b_wr_done(n_b_wr_done),
    .b_rd_req(n_b_rd_req), .b_rd_data(n_b_rd_data), .b_rd_ack(n_b_rd_ack),
    .a2b_full(n_a2b_full), .b2a_full(n_b2a_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int model_sat(input int x);
    if (x > 999) return 999;
    if (x < -999) return -999;
    return x;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // dir 0: A->B on bypass link, 1: B->A on bypass link, 2: A->B on non-bypass link
  task automatic drive(input int dir, input logic v, input logic [10:0] d, input logic r);
    case (dir)
      0: begin a_wr_valid = v; a_wr_data = d; b_rd_req = r; end
      1: begin b_wr_valid = v; b_wr_data = d; a_rd_req = r; end
      default: begin n_a_wr_valid = v; n_a_wr_data = d; n_b_rd_req = r; end
    endcase
  endtask

  task automatic sample(input int dir, output logic ack, output logic done, output logic [10:0] rdat);
    case (dir)
      0: begin ack = b_rd_ack; done = a_wr_done; rdat = b_rd_data; end
      1: begin ack = a_rd_ack; done = b_wr_done; rdat = a_rd_data; end
      default: begin ack = n_b_rd_ack; done = n_a_wr_done; rdat = n_b_rd_data; end
    endcase
  endtask

  // One transfer: writer starts in cycle 0, reader joins `delay` cycles later.
  // Reference: same-cycle meet on a bypass link completes in cycle 0; otherwise
  // the ack lands in cycle max(delay,1) and the done one cycle later.
  task automatic xfer(input int dir, input logic [10:0] d, input int delay);
    int          exp_ack, exp_done, got_ack, got_done, n_ack, n_done, expv;
    logic        ack, done;
    logic [10:0] rdat;
    string       tag;
    tag  = $sformatf("xfer%0d_d%0d", dir, delay);
    expv = model_sat(int'($signed(d)));
    if (dir != 2 && delay == 0) begin
      exp_ack  = 0;
      exp_done = 0;
    end else begin
      exp_ack  = (delay < 1) ? 1 : delay;
      exp_done = exp_ack + 1;
    end
    got_ack = -1; got_done = -1; n_ack = 0; n_done = 0;
    for (int c = 0; c <= delay + 3; c++) begin
      @(posedge clk); #1;
      drive(dir, got_done < 0, d, (c >= delay) && (got_ack < 0));
      #3;
      sample(dir, ack, done, rdat);
      if (ack) begin
        n_ack++;
        if (got_ack < 0) begin
          got_ack = c;
          check({tag, "_data"}, $signed(rdat), expv);
        end
      end else if (got_ack >= 0) begin
        check({tag, "_hold"}, $signed(rdat), expv);
      end
      if (done) begin
        n_done++;
        if (got_done < 0) got_done = c;
      end
    end
    @(posedge clk); #1;
    drive(dir, 1'b0, '0, 1'b0);
    check({tag, "_ackcyc"}, got_ack, exp_ack);
    check({tag, "_donecyc"}, got_done, exp_done);
    check({tag, "_nack"}, n_ack, 1);
    check({tag, "_ndone"}, n_done, 1);
  endtask

  initial begin
    int          dir, dly;
    logic [10:0] rd;
    rst = 1'b0;
    a_wr_valid = 0; a_rd_req = 0; b_wr_valid = 0; b_rd_req = 0;
    a_wr_data = '0; b_wr_data = '0;
    n_a_wr_valid = 0; n_a_rd_req = 0; n_b_wr_valid = 0; n_b_rd_req = 0;
    n_a_wr_data = '0; n_b_wr_data = '0;

    // Reset held with a writer pending: everything quiet
    a_wr_valid = 1'b1; a_wr_data = 11'd5;
    repeat (2) @(posedge clk);
    #4;
    check("rst_a_wr_done", a_wr_done, 0);
    check("rst_b_wr_done", b_wr_done, 0);
    check("rst_a_rd_ack", a_rd_ack, 0);
    check("rst_b_rd_ack", b_rd_ack, 0);
    check("rst_a2b_full", a2b_full, 0);
    check("rst_b2a_full", b2a_full, 0);
    check("rst_a_rd_data", a_rd_data, 0);
    check("rst_b_rd_data", b_rd_data, 0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #4;
    check("rel_a2b_full", a2b_full, 1);
    @(posedge clk); #1; b_rd_req = 1'b1;
    #3;
    check("rel_ack", b_rd_ack, 1);
    check("rel_data", $signed(b_rd_data), 5);
    check("rel_done_early", a_wr_done, 0);
    @(posedge clk); #1; b_rd_req = 1'b0;
    #3;
    check("rel_done", a_wr_done, 1);
    check("rel_ack_once", b_rd_ack, 0);
    @(posedge clk); #1; a_wr_valid = 1'b0;
    #3;
    check("rel_done_once", a_wr_done, 0);
    check("rel_empty", a2b_full, 0);
    check("rel_hold", $signed(b_rd_data), 5);

    // Delayed read, both links; same-cycle meet with and without bypass
    xfer(0, 11'd5, 3);
    xfer(2, 11'd5, 3);
    xfer(0, 11'(-7), 0);
    xfer(1, 11'(-7), 0);
    xfer(2, 11'(-7), 0);

    // Saturation at and beyond the limits
    xfer(0, 11'd1000, 1);
    xfer(0, 11'd1023, 0);
    xfer(1, 11'(-1000), 2);
    xfer(2, 11'(-1024), 1);
    xfer(0, 11'd999, 1);
    xfer(1, 11'(-999), 1);

    // Cross writes: both slots fill and wait, then both reads complete together
    @(posedge clk); #1;
    a_wr_valid = 1'b1; a_wr_data = 11'd3;
    b_wr_valid = 1'b1; b_wr_data = 11'd4;
    @(posedge clk); #4;
    check("x_a2b_full", a2b_full, 1);
    check("x_b2a_full", b2a_full, 1);
    check("x_no_ack_a", a_rd_ack, 0);
    check("x_no_ack_b", b_rd_ack, 0);
    @(posedge clk); #1;
    a_rd_req = 1'b1; b_rd_req = 1'b1;
    #3;
    check("x_a_ack", a_rd_ack, 1);
    check("x_b_ack", b_rd_ack, 1);
    check("x_a_data", $signed(a_rd_data), 4);
    check("x_b_data", $signed(b_rd_data), 3);
    @(posedge clk); #1;
    a_rd_req = 1'b0; b_rd_req = 1'b0;
    #3;
    check("x_a_done", a_wr_done, 1);
    check("x_b_done", b_wr_done, 1);
    @(posedge clk); #1;
    a_wr_valid = 1'b0; b_wr_valid = 1'b0;
    #3;
    check("x_a2b_empty", a2b_full, 0);
    check("x_b2a_empty", b2a_full, 0);

    // Reset while a word waits: slot cleared, later read stalls
    @(posedge clk); #1;
    a_wr_valid = 1'b1; a_wr_data = 11'd42;
    @(posedge clk); #4;
    check("r6_full", a2b_full, 1);
    @(posedge clk); #1;
    rst = 1'b0; a_wr_valid = 1'b0;
    #3;
    check("r6_cleared", a2b_full, 0);
    check("r6_no_done", a_wr_done, 0);
    @(posedge clk); #1; rst = 1'b1;
    b_rd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #4;
      check("r6_stall_ack", b_rd_ack, 0);
      check("r6_stall_done", a_wr_done, 0);
    end
    check("r6_data_cleared", b_rd_data, 0);
    @(posedge clk); #1; b_rd_req = 1'b0;

    // Randomised transfers against the reference model
    for (int i = 0; i < 24; i++) begin
      dir = int'($urandom_range(0, 2));
      dly = int'($urandom_range(0, 3));
      rd  = 11'($urandom_range(0, 2047));
      xfer(dir, rd, dly);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
